// File: rtl/mux161_scan_ctrl_pkg.sv
// Shared types and constants for the 16:1 mux scan controller.
package mux161_scan_ctrl_pkg;

   // Sequencer states.
   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StScan = 1'b1
   } state_e;

   localparam int unsigned NumCh         = 16;
   localparam int unsigned DefaultSettle = 1;
   // Width of the settle counter; SETTLE must fit (0..15).
   localparam int unsigned CntW          = 4;

endpackage

// File: rtl/mux161_scan_ctrl_if.sv
// Bus between the scan controller and its environment: request controls, the mux tap,
// the mux select and the assembled word.
interface mux161_scan_ctrl_if #(
   parameter int unsigned N_SEL = 4
);
   logic                  start;
   logic                  cont;
   logic                  mux_y;
   logic [N_SEL-1:0]      sel;
   logic [2**N_SEL-1:0]   data;
   logic                  valid;
   logic                  busy;

   // Environment side: issues requests, presents the mux output, consumes the word.
   modport master (
      output start, cont, mux_y,
      input  sel, data, valid, busy
   );

   // Controller side.
   modport slave (
      input  start, cont, mux_y,
      output sel, data, valid, busy
   );
endinterface

// File: rtl/mux161_scan_ctrl_scan_settle_cnt.sv
// Loadable down-counter with a zero flag; times the settle window of each channel.
module scan_settle_cnt
   import mux161_scan_ctrl_pkg::*;
#(
   parameter int unsigned Width = CntW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);
   logic [Width-1:0] cnt_q, cnt_d;

   // Load has priority over decrement; decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mux161_scan_ctrl.sv
// Scan sequencer for a 16:1 mux: steps the select through every channel, samples y at the
// end of each channel window, and publishes the assembled word with a one-cycle valid.
module mux161_scan_ctrl
   import mux161_scan_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE = DefaultSettle,
   parameter int unsigned N_SEL  = 4
) (
   input  logic             clk,
   input  logic             rst,
   mux161_scan_ctrl_if.slave bus
);
   localparam int unsigned    NCh       = 2 ** N_SEL;
   localparam logic [CntW-1:0] SettleVal = CntW'(SETTLE);
   localparam logic [N_SEL-1:0] LastSel  = N_SEL'(NCh - 1);

   state_e           state_q, state_d;
   logic [N_SEL-1:0] sel_q, sel_d;
   logic [NCh-1:0]   acc_q, acc_d;
   logic [NCh-1:0]   data_q, data_d;
   logic             valid_q, valid_d;
   logic             cnt_load, cnt_dec, cnt_zero;

   scan_settle_cnt #(
      .Width (CntW)
   ) u_settle_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (SettleVal),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // Next-state logic: channel walk, sampling and end-of-scan hand-off.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      acc_d    = acc_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d  = StScan;
               sel_d    = '0;
               cnt_load = 1'b1;
            end
         end
         StScan: begin
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else begin
               // Last edge of this channel's window: y has been stable for a full cycle.
               acc_d[sel_q] = bus.mux_y;
               if (sel_q != LastSel) begin
                  sel_d    = sel_q + 1'b1;
                  cnt_load = 1'b1;
               end else begin
                  // Whole word moves at once, including the sample taken on this edge.
                  data_d  = acc_d;
                  valid_d = 1'b1;
                  sel_d   = '0;
                  if (bus.cont) begin
                     cnt_load = 1'b1;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sel_q   <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign bus.sel   = sel_q;
   assign bus.data  = data_q;
   assign bus.valid = valid_q;
   assign bus.busy  = (state_q == StScan);
endmodule

// File: tb/tb_mux161_scan_ctrl.sv
// Bench for mux161_scan_ctrl: two instances (SETTLE=1 and SETTLE=0) share stimulus; a
// channel-window model predicts every output each cycle, with directed literal checks on top.
module tb_mux161_scan_ctrl;
   import mux161_scan_ctrl_pkg::*;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic        cont  = 1'b0;
   logic [15:0] ipat  = '0;
   bit          chk_en = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mux161_scan_ctrl_if #(.N_SEL(4)) if0 ();
   mux161_scan_ctrl_if #(.N_SEL(4)) if1 ();

   // Behavioural 16:1 mux feeding each DUT.
   assign if0.start = start;
   assign if0.cont  = cont;
   assign if0.mux_y = ipat[if0.sel];
   assign if1.start = start;
   assign if1.cont  = cont;
   assign if1.mux_y = ipat[if1.sel];

   mux161_scan_ctrl #(.SETTLE(1), .N_SEL(4)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   mux161_scan_ctrl #(.SETTLE(0), .N_SEL(4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

   logic [3:0]  d_sel   [2];
   logic [15:0] d_data  [2];
   logic        d_valid [2];
   logic        d_busy  [2];

   always_comb begin
      d_sel[0] = if0.sel;  d_data[0] = if0.data;  d_valid[0] = if0.valid;  d_busy[0] = if0.busy;
      d_sel[1] = if1.sel;  d_data[1] = if1.data;  d_valid[1] = if1.valid;  d_busy[1] = if1.busy;
   end

   function automatic int settle_of(input int d);
      return (d == 0) ? 1 : 0;
   endfunction

   // ---------------- model: position within the scan, in clock edges ----------------
   bit          m_scan  [2];
   int          m_pos   [2];
   logic [15:0] m_word  [2];
   logic [15:0] m_data  [2];
   bit          m_valid [2];

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         int w;
         int ch;
         w = settle_of(d) + 1;
         if (rst) begin
            m_scan[d] = 1'b0; m_pos[d] = 0; m_word[d] = '0; m_data[d] = '0; m_valid[d] = 1'b0;
         end else begin
            m_valid[d] = 1'b0;
            if (!m_scan[d]) begin
               if (start) begin
                  m_scan[d] = 1'b1;
                  m_pos[d]  = 0;
               end
            end else begin
               ch = m_pos[d] / w;
               if ((m_pos[d] % w) == w - 1) m_word[d][ch] = ipat[ch];
               m_pos[d]++;
               if (m_pos[d] == 16 * w) begin
                  m_data[d]  = m_word[d];
                  m_valid[d] = 1'b1;
                  m_pos[d]   = 0;
                  if (!cont) m_scan[d] = 1'b0;
               end
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   task automatic check(input string name, input int d, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, d, got, want, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            int es;
            es = m_scan[d] ? m_pos[d] / (settle_of(d) + 1) : 0;
            check("sel",   d, 32'(d_sel[d]),   32'(es));
            check("data",  d, 32'(d_data[d]),  32'(m_data[d]));
            check("valid", d, 32'(d_valid[d]), 32'(m_valid[d]));
            check("busy",  d, 32'(d_busy[d]),  32'(m_scan[d]));
         end
      end
   end

   // ---------------- directed window helper ----------------
   int          v_cnt   [2];
   int          v_when  [2][8];
   logic [15:0] v_d     [2][8];
   int          first_low [2];

   // Pulses start, then watches ncyc cycles; edge offsets are relative to the start edge.
   task automatic window(input int ncyc, input int repulse, input int pat_at,
                         input logic [15:0] pat2, input int cont_off);
      for (int d = 0; d < 2; d++) begin
         v_cnt[d] = 0;
         first_low[d] = 0;
      end
      start = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         start = (c == repulse);
         if (c == pat_at) ipat = pat2;
         if (c == cont_off) cont = 1'b0;
         for (int d = 0; d < 2; d++) begin
            if (d_valid[d] && v_cnt[d] < 8) begin
               v_when[d][v_cnt[d]] = c - 1;
               v_d[d][v_cnt[d]]    = d_data[d];
               v_cnt[d]++;
            end
            if (!d_busy[d] && first_low[d] == 0) first_low[d] = c;
         end
      end
   endtask

   initial begin
      bit found;

      // Test 1: reset held three cycles.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_sel", d, 32'(d_sel[d]), 0);
         check("rst_data", d, 32'(d_data[d]), 0);
         check("rst_valid", d, 32'(d_valid[d]), 0);
         check("rst_busy", d, 32'(d_busy[d]), 0);
      end
      chk_en = 1'b1;
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Test 2 (and 6 on dut1): single scan of A5C3.
      ipat = 16'hA5C3;
      window(40, -1, -1, 16'h0, -1);
      check("t2_nvalid", 0, v_cnt[0], 1);
      check("t2_latency", 0, v_when[0][0], 32);
      check("t2_data", 0, 32'(v_d[0][0]), 32'hA5C3);
      check("t2_busy_drop", 0, first_low[0], 33);
      check("t2_model", 0, 32'(m_data[0]), 32'hA5C3);
      check("t6_latency", 1, v_when[1][0], 16);
      check("t6_data", 1, 32'(v_d[1][0]), 32'hA5C3);
      check("t6_busy_drop", 1, first_low[1], 17);

      // Reset in the middle of idle clears the held word.
      rst = 1'b1;
      @(negedge clk);
      check("idle_rst_data", 0, 32'(d_data[0]), 0);
      rst = 1'b0;
      @(negedge clk);

      // Test 3: start re-pulsed mid-scan is ignored.
      ipat = 16'h3C5A;
      window(45, 10, -1, 16'h0, -1);
      check("t3_nvalid", 0, v_cnt[0], 1);
      check("t3_nvalid", 1, v_cnt[1], 1);
      check("t3_data", 0, 32'(v_d[0][0]), 32'h3C5A);
      ipat = 16'h0F0F;
      window(40, -1, -1, 16'h0, -1);
      check("t3_data2", 0, 32'(v_d[0][0]), 32'h0F0F);
      check("t3_data2", 1, 32'(v_d[1][0]), 32'h0F0F);

      // Test 4: continuous mode, pattern changed between scans, then cont dropped.
      cont = 1'b1;
      ipat = 16'h1234;
      window(110, -1, 33, 16'hFFFF, 65);
      check("t4_nvalid", 0, v_cnt[0], 3);
      check("t4_when0", 0, v_when[0][0], 32);
      check("t4_when1", 0, v_when[0][1], 64);
      check("t4_when2", 0, v_when[0][2], 96);
      check("t4_data0", 0, 32'(v_d[0][0]), 32'h1234);
      check("t4_data1", 0, 32'(v_d[0][1]), 32'hFFFF);
      check("t4_busy_drop", 0, first_low[0], 97);
      check("t4_nvalid", 1, v_cnt[1], 5);

      // Test 5: reset while sel=7 discards the partial scan.
      ipat = 16'hFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (d_sel[0] == 4'd7) found = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL t5_sel7_wait dut0: got timeout want sel=7");
      end
      rst = 1'b1;
      @(negedge clk);
      check("t5_sel", 0, 32'(d_sel[0]), 0);
      check("t5_data", 0, 32'(d_data[0]), 0);
      check("t5_valid", 0, 32'(d_valid[0]), 0);
      check("t5_busy", 0, 32'(d_busy[0]), 0);
      rst = 1'b0;
      @(negedge clk);
      ipat = 16'h0001;
      window(40, -1, -1, 16'h0, -1);
      check("t5_data_after", 0, 32'(v_d[0][0]), 32'h0001);
      check("t5_data_after", 1, 32'(v_d[1][0]), 32'h0001);

      // Test 6 explicit pattern on the SETTLE=0 instance.
      ipat = 16'h8001;
      window(40, -1, -1, 16'h0, -1);
      check("t6_latency2", 1, v_when[1][0], 16);
      check("t6_data2", 1, 32'(v_d[1][0]), 32'h8001);
      check("t6_model", 1, 32'(m_data[1]), 32'h8001);

      // Randomised traffic: starts, cont toggling, pattern changes, occasional reset.
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 49) == 0) cont = ~cont;
         if ($urandom_range(0, 19) == 0) ipat = 16'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      start = 1'b0;
      cont = 1'b0;
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
